// File: rtl/vga_timing_pkg.sv
// VGA timing package: default 800x600@72 constants,
// axis phase enum and shared timing helper functions.
package vga_timing_pkg;

   localparam int H_VISIBLE_D = 800;
   localparam int H_FRONT_D   = 56;
   localparam int H_SYNC_D    = 120;
   localparam int H_BACK_D    = 64;

   localparam int V_VISIBLE_D = 600;
   localparam int V_FRONT_D   = 37;
   localparam int V_SYNC_D    = 6;
   localparam int V_BACK_D    = 23;

   localparam int COL_W = 12;
   localparam int ROW_W = 11;

   typedef enum logic [1:0] {
      PH_VISIBLE,
      PH_FRONT,
      PH_SYNC,
      PH_BACK
   } phase_e;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } run_state_e;

   function automatic int axis_total(
      input int visible,
      input int front,
      input int sync,
      input int back
   );
      return visible + front + sync + back;
   endfunction

   function automatic phase_e axis_phase(
      input int count,
      input int visible,
      input int front,
      input int sync
   );
      if (count < visible)
         return PH_VISIBLE;
      else if (count < visible + front)
         return PH_FRONT;
      else if (count < visible + front + sync)
         return PH_SYNC;
      else
         return PH_BACK;
   endfunction

   localparam int H_TOTAL_D =
      axis_total(H_VISIBLE_D, H_FRONT_D,
                 H_SYNC_D, H_BACK_D);
   localparam int V_TOTAL_D =
      axis_total(V_VISIBLE_D, V_FRONT_D,
                 V_SYNC_D, V_BACK_D);

endpackage

// File: rtl/vga_sync_generator_if.sv
// Sync bundle from the timing generator to the
// position tracker, pixel pipeline and output pins.
interface vga_sync_generator_if;

   logic [11:0] display_col;
   logic [10:0] display_row;
   logic        visible;
   logic        hsync;
   logic        vsync;
   logic        line_start;
   logic        frame_start;

   modport master (
      output display_col,
      output display_row,
      output visible,
      output hsync,
      output vsync,
      output line_start,
      output frame_start
   );

   modport slave (
      input display_col,
      input display_row,
      input visible,
      input hsync,
      input vsync,
      input line_start,
      input frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus the
// phase of the position that takes effect on this edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_D,
   parameter int FRONT   = H_FRONT_D,
   parameter int SYNC    = H_SYNC_D,
   parameter int BACK    = H_BACK_D,
   parameter int WIDTH   = COL_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             step,
   input  logic             load0,
   output logic [WIDTH-1:0] count,
   output phase_e           phase,
   output logic             wrap
);

   localparam int TOTAL =
      axis_total(VISIBLE, FRONT, SYNC, BACK);
   localparam logic [WIDTH-1:0] LAST =
      WIDTH'(TOTAL - 1);

   logic [WIDTH-1:0] count_nxt;
   logic             at_last;

   assign at_last = (count == LAST);

   // wrap only fires on an edge that actually steps
   // past the terminal count
   assign wrap = step & at_last & ~load0;

   // next position: load0 beats step, wrap to zero at end
   always_comb begin
      count_nxt = count;
      if (load0)
         count_nxt = '0;
      else if (step)
         count_nxt = at_last ? '0 : count + 1'b1;
   end

   // phase is decoded from the next position so the top
   // can register it alongside the count itself
   assign phase = axis_phase(int'(count_nxt),
                             VISIBLE, FRONT, SYNC);

   // position register
   always_ff @(posedge clock) begin
      if (!reset_n)
         count <= '0;
      else
         count <= count_nxt;
   end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA sync generator: IDLE/RUN control, two axis
// counters and registered, zero-latency output decode.
module vga_sync_generator
   import vga_timing_pkg::*;
#(
   parameter int   H_VISIBLE    = H_VISIBLE_D,
   parameter int   H_FRONT      = H_FRONT_D,
   parameter int   H_SYNC       = H_SYNC_D,
   parameter int   H_BACK       = H_BACK_D,
   parameter int   V_VISIBLE    = V_VISIBLE_D,
   parameter int   V_FRONT      = V_FRONT_D,
   parameter int   V_SYNC       = V_SYNC_D,
   parameter int   V_BACK       = V_BACK_D,
   parameter logic HSYNC_ACTIVE = 1'b1,
   parameter logic VSYNC_ACTIVE = 1'b1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   vga_sync_generator_if.master sync
);

   run_state_e state_q;
   run_state_e state_d;

   logic load0;
   logic step;

   logic [COL_W-1:0] h_count;
   logic [ROW_W-1:0] v_count;
   phase_e           h_phase;
   phase_e           v_phase;
   logic             h_wrap;
   logic             v_wrap;

   logic visible_q;
   logic hsync_q;
   logic vsync_q;
   logic line_start_q;
   logic frame_start_q;

   // control state register
   always_ff @(posedge clock) begin
      if (!reset_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // first enabled edge loads (0,0) without counting,
   // afterwards every enabled edge advances one pixel
   always_comb begin
      state_d = state_q;
      load0   = 1'b0;
      step    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) begin
               load0   = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            step = enable;
         end
      endcase
   end

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .WIDTH   (COL_W)
   ) u_h_axis (
      .clock   (clock),
      .reset_n (reset_n),
      .step    (step),
      .load0   (load0),
      .count   (h_count),
      .phase   (h_phase),
      .wrap    (h_wrap)
   );

   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .WIDTH   (ROW_W)
   ) u_v_axis (
      .clock   (clock),
      .reset_n (reset_n),
      .step    (h_wrap),
      .load0   (load0),
      .count   (v_count),
      .phase   (v_phase),
      .wrap    (v_wrap)
   );

   // outputs decoded from the next position so they
   // line up with the counters; frozen while disabled
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         visible_q     <= 1'b0;
         hsync_q       <= ~HSYNC_ACTIVE;
         vsync_q       <= ~VSYNC_ACTIVE;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (enable) begin
         visible_q     <= (h_phase == PH_VISIBLE) &&
                          (v_phase == PH_VISIBLE);
         hsync_q       <= (h_phase == PH_SYNC) ?
                          HSYNC_ACTIVE : ~HSYNC_ACTIVE;
         vsync_q       <= (v_phase == PH_SYNC) ?
                          VSYNC_ACTIVE : ~VSYNC_ACTIVE;
         line_start_q  <= load0 | h_wrap;
         frame_start_q <= load0 | v_wrap;
      end
   end

   assign sync.display_col = h_count;
   assign sync.display_row = v_count;
   assign sync.visible     = visible_q;
   assign sync.hsync       = hsync_q;
   assign sync.vsync       = vsync_q;
   assign sync.line_start  = line_start_q;
   assign sync.frame_start = frame_start_q;

endmodule
